mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15, max cycles waited for dmemAck before abort; legal range 1..255.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 validIn  in  1  EX result present this cycle; sampled only when stall low.
REQ-005 aluRes  in  32  EX result; effective address for load/store, pass-through value otherwise.
REQ-006 busB  in  32  store data, right-justified.
REQ-007 memRd, memWr  in  1 each  load / store request.
REQ-008 memSize  in  2  00 byte, 01 half, 10 word; 11 reserved.
REQ-009 signExt  in  1  load sign-extends when high, zero-extends when low.
REQ-010 dmemAddr  out  32  word-aligned address (low 2 bits zero).
REQ-011 dmemWData  out  32  store data placed in byte lanes.
REQ-012 dmemBe  out  4  byte enables; bit3 = bits 31:24.
REQ-013 dmemRe, dmemWe  out  1 each  memory read / write strobes.
REQ-014 dmemAck  in  1  memory completion, single cycle.
REQ-015 dmemRData  in  32  read data, valid in the dmemAck cycle.
REQ-016 memRes  out  32  load result or pass-through aluRes.
REQ-017 validOut  out  1  memRes valid, one-cycle pulse per accepted op.
REQ-018 stall  out  1  upstream must hold inputs while high.
REQ-019 err  out  1  one-cycle pulse on aborted access.

Function
REQ-020 States IDLE, ACCESS and DONE; all outputs registered.
REQ-021 IDLE, validIn, memRd=memWr=0: memRes<=aluRes, validOut pulses next cycle, state stays IDLE (latency 1).
REQ-022 IDLE, validIn, exactly one of memRd/memWr: latch address, data and size; enter ACCESS; stall high from the next cycle.
REQ-023 ACCESS: dmemRe or dmemWe held high with stable dmemAddr/dmemBe/dmemWData until dmemAck.
REQ-024 Byte lanes are big-endian: byte offset 0 maps to bits 31:24; half offset 0 maps to bits 31:16.
REQ-025 dmemBe: byte = one-hot per offset; half = 1100 or 0011; word = 1111.
REQ-026 Store data is replicated into the selected lanes.
REQ-027 dmemAck in ACCESS: drop strobes; extract the load lane and extend it to 32 bits per signExt; enter DONE.
REQ-028 DONE: validOut=1, stall=0; return to IDLE; memRes holds its value until the next validOut.
REQ-029 A store in DONE pulses validOut with memRes = aluRes.
REQ-030 Timeout counter is cleared on entry to ACCESS; if ACK_TIMEOUT cycles elapse without dmemAck: drop strobes, pulse err, pulse no validOut, return to IDLE.
REQ-031 memRd and memWr both high, or memSize=11: no memory access; err pulses next cycle; no validOut.
REQ-032 dmemAck outside ACCESS is ignored.

Reset
REQ-033 rst has priority over all inputs: state IDLE; memRes=0; validOut, stall, err, dmemRe, dmemWe, dmemBe all 0; dmemAddr and dmemWData = 0; timeout counter = 0.
REQ-034 rst during ACCESS abandons the access with no err pulse; strobes are low the following cycle.

Configuration
REQ-035 MEM_MISALIGN_TRAP_EN defined: a half access at odd address or a word access with addr[1:0]!=0 is rejected as in REQ-031, with no strobe.
REQ-036 MEM_MISALIGN_TRAP_EN undefined: the low address bits are ignored for the access size; half uses addr[1] only; word uses offset 0.

Structure
REQ-037 Shared package cpu_pkg holds the memSize encodings, the state enum and the ACK_TIMEOUT default.
REQ-038 Sub-module mem_align holds the combinational lane placement, byte-enable generation and load extraction/extension; the FSM stays in mem_stage.

Verification
REQ-039 Pass-through: aluRes=123, no memRd/memWr -> validOut next cycle, memRes=123, stall stays 0.
REQ-040 Signed byte load: addr=0x1001, signExt=1, dmemRData=0x12F45678, ack after 2 cycles -> dmemBe=0100, memRes=0xFFFFFFF4, stall high 3 cycles.
REQ-041 Half store: addr=0x2002, busB=0xABCD -> dmemBe=0011, dmemWData=0xABCDABCD, dmemWe until ack, then validOut.
REQ-042 Timeout: ACK_TIMEOUT=4, ack never arrives -> strobes drop after 4 ACCESS cycles, err pulses, no validOut.
REQ-043 Misaligned word load at 0x3002 with MEM_MISALIGN_TRAP_EN -> err pulse, dmemRe never high; without the macro -> access to 0x3000 with dmemBe=1111.
REQ-044 rst asserted in the 2nd ACCESS cycle -> next cycle all outputs 0, state IDLE, a late dmemAck is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory stage: access-size encodings, FSM states
// and the default acknowledge timeout.
package cpu_pkg;

  localparam int unsigned ACK_TIMEOUT_DEFAULT = 15;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } memStateT;

endpackage

// File: rtl/mem_align.sv
// Combinational big-endian lane logic: store lane placement / byte enables
// and load lane extraction with sign or zero extension.
module mem_align
  import cpu_pkg::*;
(
  input  logic [1:0]  addrLo,
  input  logic [1:0]  size,
  input  logic [31:0] storeData,
  output logic [3:0]  be_c,
  output logic [31:0] wData_c,
  input  logic [1:0]  ldOff,
  input  logic [1:0]  ldSize,
  input  logic        ldSignExt,
  input  logic [31:0] rData,
  output logic [31:0] ldData_c
);

  logic [7:0]  ldByte;
  logic [15:0] ldHalf;

  // Store side: half accesses only look at addr[1], words always use lane 0.
  always_comb begin
    be_c    = 4'b0000;
    wData_c = 32'h0;
    case (size)
      SIZE_BYTE: begin
        be_c    = 4'b1000 >> addrLo;
        wData_c = {4{storeData[7:0]}};
      end
      SIZE_HALF: begin
        be_c    = addrLo[1] ? 4'b0011 : 4'b1100;
        wData_c = {2{storeData[15:0]}};
      end
      SIZE_WORD: begin
        be_c    = 4'b1111;
        wData_c = storeData;
      end
      default: begin
        be_c    = 4'b0000;
        wData_c = 32'h0;
      end
    endcase
  end

  // Load side: offset 0 is the most significant lane.
  always_comb begin
    case (ldOff)
      2'd0:    ldByte = rData[31:24];
      2'd1:    ldByte = rData[23:16];
      2'd2:    ldByte = rData[15:8];
      default: ldByte = rData[7:0];
    endcase
    ldHalf = ldOff[1] ? rData[15:0] : rData[31:16];
    case (ldSize)
      SIZE_BYTE: ldData_c = {{24{ldSignExt & ldByte[7]}}, ldByte};
      SIZE_HALF: ldData_c = {{16{ldSignExt & ldHalf[15]}}, ldHalf};
      SIZE_WORD: ldData_c = rData;
      default:   ldData_c = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: pass-through or single load/store with ack timeout.
// Optional MEM_MISALIGN_TRAP_EN rejects misaligned half/word accesses.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validIn,
  input  logic [31:0] aluRes,
  input  logic [31:0] busB,
  input  logic        memRd,
  input  logic        memWr,
  input  logic [1:0]  memSize,
  input  logic        signExt,
  output logic [31:0] dmemAddr,
  output logic [31:0] dmemWData,
  output logic [3:0]  dmemBe,
  output logic        dmemRe,
  output logic        dmemWe,
  input  logic        dmemAck,
  input  logic [31:0] dmemRData,
  output logic [31:0] memRes,
  output logic        validOut,
  output logic        stall,
  output logic        err
);

  memStateT    state;
  logic [7:0]  toCnt;
  logic [1:0]  ldOff;
  logic [1:0]  ldSize;
  logic        ldSignExt;
  logic [31:0] aluLat;

  logic [3:0]  be_c;
  logic [31:0] wData_c;
  logic [31:0] ldData_c;
  logic        memOp_c;
  logic        opErr_c;

  mem_align uAlign (
    .addrLo    (aluRes[1:0]),
    .size      (memSize),
    .storeData (busB),
    .be_c      (be_c),
    .wData_c   (wData_c),
    .ldOff     (ldOff),
    .ldSize    (ldSize),
    .ldSignExt (ldSignExt),
    .rData     (dmemRData),
    .ldData_c  (ldData_c)
  );

  assign memOp_c = memRd | memWr;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned_c;
  assign misaligned_c = ((memSize == SIZE_HALF) && aluRes[0]) ||
                        ((memSize == SIZE_WORD) && (aluRes[1:0] != 2'b00));
  assign opErr_c = (memRd & memWr) | (memOp_c & ((memSize == SIZE_RSVD) | misaligned_c));
`else
  assign opErr_c = (memRd & memWr) | (memOp_c & (memSize == SIZE_RSVD));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      toCnt     <= 8'd0;
      ldOff     <= 2'b00;
      ldSize    <= 2'b00;
      ldSignExt <= 1'b0;
      aluLat    <= 32'h0;
      memRes    <= 32'h0;
      validOut  <= 1'b0;
      stall     <= 1'b0;
      err       <= 1'b0;
      dmemRe    <= 1'b0;
      dmemWe    <= 1'b0;
      dmemBe    <= 4'b0000;
      dmemAddr  <= 32'h0;
      dmemWData <= 32'h0;
    end else begin
      validOut <= 1'b0;
      err      <= 1'b0;
      case (state)
        // DONE already shows stall low, so it accepts the next op like IDLE.
        IDLE, DONE: begin
          state <= IDLE;
          stall <= 1'b0;
          if (validIn) begin
            if (!memOp_c) begin
              memRes   <= aluRes;
              validOut <= 1'b1;
            end else if (opErr_c) begin
              err <= 1'b1;
            end else begin
              state     <= ACCESS;
              stall     <= 1'b1;
              toCnt     <= 8'd0;
              ldOff     <= aluRes[1:0];
              ldSize    <= memSize;
              ldSignExt <= signExt;
              aluLat    <= aluRes;
              dmemAddr  <= {aluRes[31:2], 2'b00};
              dmemBe    <= be_c;
              dmemWData <= wData_c;
              dmemRe    <= memRd;
              dmemWe    <= memWr;
            end
          end
        end
        ACCESS: begin
          if (dmemAck) begin
            dmemRe   <= 1'b0;
            dmemWe   <= 1'b0;
            stall    <= 1'b0;
            validOut <= 1'b1;
            memRes   <= dmemRe ? ldData_c : aluLat;
            state    <= DONE;
          end else if (toCnt == 8'(ACK_TIMEOUT - 1)) begin
            dmemRe <= 1'b0;
            dmemWe <= 1'b0;
            stall  <= 1'b0;
            err    <= 1'b1;
            state  <= IDLE;
          end else begin
            toCnt <= toCnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
